game_controller: RTL

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 32 +++
 rtl/tick_gen.sv | 48 ++++
 rtl/game_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game controller slice.
// Holds the FSM state encoding, the speed-level width, the default
// parameter values and a small width helper used to size counters.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_WIN     = 3'd5,
    ST_LOSE    = 3'd6
  } state_t;

  localparam int unsigned SPEED_W = 2;

  localparam int unsigned DEF_WIN_COINS     = 10;
  localparam int unsigned DEF_SCORE_W       = 4;
  localparam int unsigned DEF_LIVES         = 3;
  localparam int unsigned DEF_BASE_DIV      = 25_000_000;
  localparam int unsigned DEF_RECOVER_TICKS = 4;

  // Number of bits needed to hold values 0..max_val (at least 1).
  function automatic int unsigned bits_for(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-step tick divider.
// Produces a one-cycle tick every (BASE_DIV >> speed) enabled cycles.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high reset
//   enable - count only while high; the count is held while low
//   clear  - synchronous clear of the count
//   speed  - speed level; higher levels shorten the period
//   tick   - one-cycle strobe, decoded from the registered count
module tick_gen
  import game_pkg::*;
#(
  parameter int unsigned BASE_DIV = DEF_BASE_DIV
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  localparam int unsigned CNT_W = bits_for(BASE_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  int unsigned      period;

  // A period that shifts down to zero behaves as one cycle per tick.
  always_comb begin
    period = BASE_DIV >> speed;
    if (period == 0) period = 1;
    last = CNT_W'(period - 1);
  end

  assign tick = enable && (cnt == last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_controller.sv
// Top-level game controller: sequences a game through load, drive,
// recovery, pause and end screens, counts coins and lives, and
// generates the game-step Tick.
// Ports:
//   CLOCK_50   - system clock
//   Reset      - asynchronous active-high reset
//   EnterEn    - start / resume pulse
//   PauseEn    - pause toggle pulse
//   LoadDone   - screen and sprite load complete (level)
//   SpeedSel   - speed level, sampled when leaving LOAD
//   CoinEn     - coin collision pulse
//   PoliceEn   - police collision pulse
//   Tick       - one-cycle game-step strobe
//   DriveEn    - high while driving or recovering
//   Score      - coins collected
//   Lives      - lives remaining
//   WinScreen, LoseScreen, Paused - end / pause status
//   State      - current FSM state encoding
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned WIN_COINS     = DEF_WIN_COINS,
  parameter int unsigned SCORE_W       = DEF_SCORE_W,
  parameter int unsigned LIVES         = DEF_LIVES,
  parameter int unsigned BASE_DIV      = DEF_BASE_DIV,
  parameter int unsigned RECOVER_TICKS = DEF_RECOVER_TICKS
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               EnterEn,
  input  logic               PauseEn,
  input  logic               LoadDone,
  input  logic [1:0]         SpeedSel,
  input  logic               CoinEn,
  input  logic               PoliceEn,
  output logic               Tick,
  output logic               DriveEn,
  output logic [SCORE_W-1:0] Score,
  output logic [2:0]         Lives,
  output logic               WinScreen,
  output logic               LoseScreen,
  output logic               Paused,
  output logic [2:0]         State
);

  localparam int unsigned REC_W = bits_for(RECOVER_TICKS);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_COINS);
  localparam logic [2:0]         LIVES_VAL = 3'(LIVES);
  localparam logic [REC_W-1:0]   REC_VAL   = REC_W'(RECOVER_TICKS);

  state_t               state;
  state_t               state_nxt;
  state_t               saved;
  logic [SPEED_W-1:0]   speed;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   score_inc;
  logic [2:0]           lives;
  logic [REC_W-1:0]     rec_cnt;
  logic                 tick;
  logic                 active;
  logic                 div_clear;
  logic                 police_hit;
  logic                 coin_hit;
  logic                 coin_win;
  logic                 last_life;
  logic                 rec_expire;
  logic                 load_entry;
  logic                 pause_entry;

  // Collision and event decode shared by the FSM and the datapath.
  // Police outranks a coin in the same cycle; police is only felt in DRIVE.
  always_comb begin
    active      = (state == ST_DRIVE) || (state == ST_RECOVER);
    div_clear   = (state == ST_LOAD);
    score_inc   = score + SCORE_W'(1);
    police_hit  = (state == ST_DRIVE) && PoliceEn;
    coin_hit    = active && CoinEn && !police_hit && (score != WIN_VAL);
    coin_win    = coin_hit && (score_inc == WIN_VAL);
    last_life   = (lives <= 3'd1);
    // Recovery ends on the tick that takes the counter from 1 to 0,
    // or immediately if the counter is already 0.
    rec_expire  = (state == ST_RECOVER) &&
                  ((rec_cnt == '0) || (tick && (rec_cnt == REC_W'(1))));
    load_entry  = (state == ST_IDLE) && EnterEn;
    pause_entry = active && (state_nxt == ST_PAUSE);
  end

  tick_gen #(
    .BASE_DIV (BASE_DIV)
  ) u_tick_gen (
    .clock  (CLOCK_50),
    .reset  (Reset),
    .enable (active),
    .clear  (div_clear),
    .speed  (speed),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (EnterEn) state_nxt = ST_LOAD;
      ST_LOAD:    if (LoadDone) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        if (police_hit)   state_nxt = last_life ? ST_LOSE : ST_RECOVER;
        else if (coin_win) state_nxt = ST_WIN;
        else if (PauseEn)  state_nxt = ST_PAUSE;
      end
      ST_RECOVER: begin
        if (coin_win)        state_nxt = ST_WIN;
        else if (PauseEn)    state_nxt = ST_PAUSE;
        else if (rec_expire) state_nxt = ST_DRIVE;
      end
      ST_PAUSE:   if (PauseEn || EnterEn) state_nxt = saved;
      ST_WIN,
      ST_LOSE:    if (EnterEn) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Game datapath: score, lives, recovery counter, pause context, speed.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      score   <= '0;
      lives   <= LIVES_VAL;
      rec_cnt <= '0;
      saved   <= ST_DRIVE;
      speed   <= '0;
    end else begin
      if (load_entry) begin
        score   <= '0;
        lives   <= LIVES_VAL;
        rec_cnt <= '0;
      end else begin
        if (coin_hit) score <= score_inc;
        if (police_hit && (lives != 3'd0)) lives <= lives - 3'd1;
        if (police_hit && !last_life) begin
          rec_cnt <= REC_VAL;
        end else if ((state == ST_RECOVER) && tick && (rec_cnt != '0)) begin
          rec_cnt <= rec_cnt - REC_W'(1);
        end
      end
      if ((state == ST_LOAD) && LoadDone) speed <= SpeedSel;
      if (pause_entry) saved <= state;
    end
  end

  // Output decode.
  always_comb begin
    Tick       = tick;
    DriveEn    = active;
    Score      = score;
    Lives      = lives;
    WinScreen  = (state == ST_WIN);
    LoseScreen = (state == ST_LOSE);
    Paused     = (state == ST_PAUSE);
    State      = state;
  end

endmodule
